// File: rtl/minimig_bank_sched.sv
// Shared memory-port scheduler: DMA-priority arbitration with CPU starvation guard,
// one command per access, fixed-latency ack. Optional build macro: MINIMIG_KICK_WP_EN.
module minimig_bank_sched #(
    parameter int LATENCY    = 4,
    parameter int CPU_STARVE = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dma_req,
    input  logic       dma_we,
    input  logic [7:0] dma_bank,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [7:0] cpu_bank,
    input  logic       mem_rdy,
    output logic       mem_cmd,
    output logic       mem_we,
    output logic [7:0] mem_bank,
    output logic       mem_src,
    output logic       dma_ack,
    output logic       cpu_ack,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    localparam logic [7:0] STARVE_MAX = 8'(CPU_STARVE);
    localparam logic [3:0] WAIT_LOAD  = 4'(LATENCY - 1);

    state_t     state;
    logic [3:0] wait_cnt;
    logic [7:0] starve_cnt;
    logic       cpu_wins;
    logic       cpu_drop;

    // cpu_drop: the CPU access completes without touching memory
    always_comb begin
        cpu_wins = cpu_req && (!dma_req || starve_cnt == STARVE_MAX);
        cpu_drop = (cpu_bank == 8'h00);
`ifdef MINIMIG_KICK_WP_EN
        if (cpu_we && (cpu_bank[7] || cpu_bank[6])) begin
            cpu_drop = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wait_cnt   <= 4'd0;
            starve_cnt <= 8'd0;
            mem_cmd    <= 1'b0;
            mem_we     <= 1'b0;
            mem_bank   <= 8'h00;
            mem_src    <= 1'b0;
            dma_ack    <= 1'b0;
            cpu_ack    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            dma_ack <= 1'b0;
            cpu_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_wins) begin
                        mem_we     <= cpu_we;
                        mem_bank   <= cpu_bank;
                        mem_src    <= 1'b0;
                        starve_cnt <= 8'd0;
                        busy       <= 1'b1;
                        if (cpu_drop) begin
                            state   <= ACK;
                            cpu_ack <= 1'b1;
                        end else begin
                            state   <= ISSUE;
                            mem_cmd <= 1'b1;
                        end
                    end else if (dma_req) begin
                        mem_we   <= dma_we;
                        mem_bank <= dma_bank;
                        mem_src  <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ISSUE;
                        mem_cmd  <= 1'b1;
                        if (!cpu_req) begin
                            starve_cnt <= 8'd0;
                        end else if (starve_cnt != STARVE_MAX) begin
                            starve_cnt <= starve_cnt + 8'd1;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_rdy) begin
                        mem_cmd <= 1'b0;
                        if (LATENCY > 1) begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end else begin
                            state   <= ACK;
                            dma_ack <= mem_src;
                            cpu_ack <= !mem_src;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd1) begin
                        state   <= ACK;
                        dma_ack <= mem_src;
                        cpu_ack <= !mem_src;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ACK: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
